spin_sequencer: RTL and testbench
=================================

// Module: spin_sequencer
// PURPOSE
//  Sequences one 8-position spin cycle from a 10-bit tick-step counter.
//  - Spins at a fast, fixed step period.
//  - Decelerates by lengthening the period after every step.
//  - Lands on a latched target position, then reports the result.
//  - Sits between the game FSM (start/seed/done) and the display/LED
//    driver (pos), clocked by the system clock with an external time-base tick.
// PARAMETERS
//  INIT_PERIOD  16   ticks per step in SPIN and at DECEL entry (1..MAX_PERIOD)
//  PERIOD_STEP  8    ticks added to the period after each DECEL step (>=1)
//  MAX_PERIOD   600  saturation period; also the LAND step period (<=1023)
//  FAST_STEPS   24   number of steps taken in SPIN before DECEL (1..255)
// PORTS
//  clk     in   1   system clock, rising edge
//  reset   in   1   asynchronous, active-high; clears all state
//  tick    in   1   time-base enable; the step counter advances only when 1
//  start   in   1   level-sampled request; accepted only in IDLE
//  seed    in   3   target landing position, latched on start acceptance
//  pos     out  3   current spinner position, 0..7, wraps 7->0
//  busy    out  1   1 in SPIN, DECEL and LAND
//  done    out  1   one-cycle pulse in DONE
//  result  out  3   final position; held until the next done
// BEHAVIOUR
//  Reset values:
//   - state=IDLE; pos, result, cnt(10b), steps(8b), target all 0.
//   - period=INIT_PERIOD; busy=0; done=0.
//  Step event:
//   - Fires on the clk edge where tick=1 and cnt==period-1.
//   - On a step: pos<=pos+1 mod 8 and cnt<=0.
//   - Otherwise cnt<=cnt+1 when tick=1; cnt holds when tick=0.
//  IDLE:
//   - start=1 -> SPIN next edge; target<=seed.
//   - cnt<=0, steps<=0, period<=INIT_PERIOD; pos is not changed.
//  SPIN:
//   - Steps at INIT_PERIOD; steps increments on each step.
//   - On the step that makes steps==FAST_STEPS -> DECEL.
//  DECEL:
//   - Each step: period<=min(period+PERIOD_STEP, MAX_PERIOD), 10-bit
//     saturating arithmetic with no wrap.
//   - If that new period==MAX_PERIOD -> LAND on the same edge.
//  LAND:
//   - Steps at MAX_PERIOD.
//   - On a step whose new pos==target -> DONE; result<=new pos.
//   - LAND always takes 1..8 steps; it never exits without stepping.
//  DONE:
//   - Lasts one cycle; done=1, busy=0; -> IDLE.
//   - start in DONE is ignored.
//  start while busy is ignored; target is not re-latched.
//  seed changes after acceptance have no effect.
//  tick=0 for any duration freezes cnt, pos and state timing; no steps are lost.
//  Reset mid-spin: immediate return to reset values.
//   - pos returns to 0; done is not pulsed.
//  Outputs are registered; busy and done are decoded from the state register.
//  Latency from start accepted to busy=1 is 1 clk.
// TESTING
//  Test params: INIT_PERIOD=2, PERIOD_STEP=2, MAX_PERIOD=6, FAST_STEPS=4.
//  Stimulus: tick held 1 unless stated.
//  T1: reset, then start=1 for 1 clk with seed=1.
//   -> SPIN steps pos 1,2,3,4 at 2-clk spacing.
//   -> DECEL steps 5 (period 2), 6 (period 4).
//   -> LAND steps 7,0,1 at 6-clk spacing.
//   -> done=1 for exactly 1 clk, 32 clks after busy rises; result=1.
//  T2: as T1 with seed=6.
//   -> LAND takes 8 steps (7,0,...,6); result=6.
//   -> busy is never dropped early.
//  T3: start pulsed repeatedly while busy with seed=3, after a seed=1 start.
//   -> ignored; landing still at 1.
//   -> start held high through DONE: restart occurs only from IDLE.
//  T4: tick=0 for 50 clks in the middle of DECEL.
//   -> pos, cnt and state frozen; resumed timing is identical to T1 minus the gap.
//  T5: assert reset mid-LAND (async, between edges).
//   -> pos=0, busy=0, result=0 immediately; no done pulse.
//   -> a new start works normally.
//  T6: INIT_PERIOD=MAX_PERIOD=6.
//   -> DECEL's first step saturates -> LAND; no overflow.

Source files
------------

// File: rtl/spin_sequencer.sv
// rtl/spin_sequencer.sv - 8-position spin sequencer: fast spin, deceleration, land on target
//
// Purpose:
//   Steps a 3-bit spinner position from a tick-enabled step counter. The spin
//   runs FAST_STEPS steps at INIT_PERIOD ticks each. It then decelerates, adding
//   PERIOD_STEP to the period after every step, until the period saturates at
//   MAX_PERIOD. It then creeps at MAX_PERIOD until it lands on the target
//   latched at start, and pulses done for one cycle.
//
// Ports:
//   i_clk     system clock, rising edge
//   i_reset   asynchronous active-high reset
//   i_tick    time-base enable; step counter advances only when 1
//   i_start   level-sampled start request, accepted only in IDLE
//   i_seed    target landing position, latched when start is accepted
//   o_pos     current spinner position (0..7, wraps)
//   o_busy    1 while spinning (SPIN, DECEL, LAND)
//   o_done    one-cycle pulse when the spin has landed
//   o_result  landed position, held until the next done
module spin_sequencer #(
  parameter int INIT_PERIOD = 16,
  parameter int PERIOD_STEP = 8,
  parameter int MAX_PERIOD  = 600,
  parameter int FAST_STEPS  = 24
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_tick,
  input  logic       i_start,
  input  logic [2:0] i_seed,
  output logic [2:0] o_pos,
  output logic       o_busy,
  output logic       o_done,
  output logic [2:0] o_result
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SPIN  = 3'd1;
  localparam logic [2:0] S_DECEL = 3'd2;
  localparam logic [2:0] S_LAND  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]  r_state;
  logic [2:0]  r_pos;
  logic [2:0]  r_result;
  logic [2:0]  r_target;
  logic [9:0]  r_cnt;
  logic [9:0]  r_period;
  logic [7:0]  r_steps;

  logic        w_running;
  logic        w_step;
  logic [2:0]  w_pos_next;
  logic [10:0] w_sum;
  logic [9:0]  w_period_next;

  assign w_running  = (r_state == S_SPIN) || (r_state == S_DECEL) || (r_state == S_LAND);
  assign w_step     = w_running && i_tick && (r_cnt == (r_period - 10'd1));
  assign w_pos_next = r_pos + 3'd1;

  // One extra bit so the period add can never wrap before saturation.
  assign w_sum         = {1'b0, r_period} + 11'(PERIOD_STEP);
  assign w_period_next = (w_sum >= 11'(MAX_PERIOD)) ? 10'(MAX_PERIOD) : w_sum[9:0];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state  <= S_IDLE;
      r_pos    <= 3'd0;
      r_result <= 3'd0;
      r_target <= 3'd0;
      r_cnt    <= 10'd0;
      r_period <= 10'(INIT_PERIOD);
      r_steps  <= 8'd0;
    end else begin
      // Shared step counter for all running states; frozen while tick is low.
      if (w_running) begin
        if (w_step) begin
          r_pos <= w_pos_next;
          r_cnt <= 10'd0;
        end else if (i_tick) begin
          r_cnt <= r_cnt + 10'd1;
        end
      end

      case (r_state)
        S_IDLE: begin
          r_cnt    <= 10'd0;
          r_steps  <= 8'd0;
          r_period <= 10'(INIT_PERIOD);
          if (i_start) begin
            r_target <= i_seed;
            r_state  <= S_SPIN;
          end
        end
        S_SPIN: begin
          if (w_step) begin
            r_steps <= r_steps + 8'd1;
            if ((r_steps + 8'd1) == 8'(FAST_STEPS)) begin
              r_state <= S_DECEL;
            end
          end
        end
        S_DECEL: begin
          // The period lengthens after the step that used the old period.
          if (w_step) begin
            r_period <= w_period_next;
            if (w_period_next == 10'(MAX_PERIOD)) begin
              r_state <= S_LAND;
            end
          end
        end
        S_LAND: begin
          // Compare the new position, so LAND always takes at least one step.
          if (w_step && (w_pos_next == r_target)) begin
            r_result <= w_pos_next;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_pos    = r_pos;
  assign o_result = r_result;
  assign o_busy   = w_running;
  assign o_done   = (r_state == S_DONE);

endmodule

// File: tb/tb_spin_sequencer.sv
// tb/tb_spin_sequencer.sv - directed self-checking bench for spin_sequencer
module tb_spin_sequencer;

  logic       clk;
  logic       reset;
  logic       tick;
  logic       start;
  logic [2:0] seed;

  logic [2:0] a_pos, a_result;
  logic       a_busy, a_done;
  logic [2:0] b_pos, b_result;
  logic       b_busy, b_done;

  int n_checks = 0;
  int n_fail   = 0;

  spin_sequencer #(
    .INIT_PERIOD(2), .PERIOD_STEP(2), .MAX_PERIOD(6), .FAST_STEPS(4)
  ) u_dut (
    .i_clk(clk), .i_reset(reset), .i_tick(tick), .i_start(start), .i_seed(seed),
    .o_pos(a_pos), .o_busy(a_busy), .o_done(a_done), .o_result(a_result)
  );

  spin_sequencer #(
    .INIT_PERIOD(6), .PERIOD_STEP(2), .MAX_PERIOD(6), .FAST_STEPS(4)
  ) u_dut_sat (
    .i_clk(clk), .i_reset(reset), .i_tick(tick), .i_start(start), .i_seed(seed),
    .o_pos(b_pos), .o_busy(b_busy), .o_done(b_done), .o_result(b_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    tick  = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Accept a start, then count clocks from busy rising to the done pulse.
  // sel=1 observes the saturating instance. gap_at/gap_len drop tick for a
  // window; hold_at raises start (seed=3) while busy and leaves it high.
  task automatic run_spin(input string tag, input bit sel, input logic [2:0] sd,
                          input int exp_cycles, input int exp_result,
                          input bit chk_pos, input int gap_at, input int gap_len,
                          input int hold_at);
    int n;
    int k;
    int exp_pos;
    bit got;
    int step_t[9];
    step_t  = '{2, 4, 6, 8, 10, 14, 20, 26, 32};
    n       = 0;
    k       = 0;
    exp_pos = 0;
    got     = 1'b0;
    @(negedge clk);
    start = 1'b1;
    seed  = sd;
    @(posedge clk);
    #1;
    start = 1'b0;
    seed  = 3'd7;
    check({tag, "_busy_rise"}, sel ? b_busy : a_busy, 1);
    while (n < 300 && !got) begin
      @(posedge clk);
      #1;
      n++;
      if (chk_pos) begin
        if (k < 9 && n == step_t[k]) begin
          exp_pos = (exp_pos + 1) % 8;
          k++;
        end
        check({tag, "_pos"}, a_pos, exp_pos);
      end
      if (n > gap_at && n <= gap_at + gap_len) begin
        check({tag, "_frozen_pos"}, a_pos, 5);
      end
      if (sel ? b_done : a_done) begin
        got = 1'b1;
      end else begin
        check({tag, "_busy_held"}, sel ? b_busy : a_busy, 1);
      end
      if (n == gap_at) begin
        @(negedge clk);
        tick = 1'b0;
      end
      if (gap_at > 0 && n == gap_at + gap_len) begin
        @(negedge clk);
        tick = 1'b1;
      end
      if (hold_at > 0 && n == hold_at) begin
        @(negedge clk);
        start = 1'b1;
        seed  = 3'd3;
      end
    end
    check({tag, "_done_seen"}, int'(got), 1);
    check({tag, "_done_latency"}, n, exp_cycles);
    check({tag, "_result"}, sel ? b_result : a_result, exp_result);
    check({tag, "_busy_in_done"}, sel ? b_busy : a_busy, 0);
    @(posedge clk);
    #1;
    check({tag, "_done_width"}, sel ? b_done : a_done, 0);
    check({tag, "_idle_after"}, sel ? b_busy : a_busy, 0);
  endtask

  initial begin
    reset = 1'b1;
    tick  = 1'b1;
    start = 1'b0;
    seed  = 3'd0;
    #12;
    check("rst_pos", a_pos, 0);
    check("rst_busy", a_busy, 0);
    check("rst_done", a_done, 0);
    check("rst_result", a_result, 0);
    check("rst_sat_busy", b_busy, 0);
    @(negedge clk);
    reset = 1'b0;

    // T1: seed=1, full pos sequence and 32-clock latency
    run_spin("t1", 1'b0, 3'd1, 32, 1, 1'b1, 0, 0, 0);
    check("t1_pos_held", a_pos, 1);

    // T2: seed=6 forces an 8-step LAND: 6+6*6+... done at 20+7*6=62
    do_reset();
    run_spin("t2", 1'b0, 3'd6, 62, 6, 1'b0, 0, 0, 0);

    // T5: from pos=6/result=6, reset asynchronously mid-LAND
    @(negedge clk);
    start = 1'b1;
    seed  = 3'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (24) @(posedge clk);
    #1;
    check("t5_pre_busy", a_busy, 1);
    check("t5_pre_result", a_result, 6);
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("t5_async_pos", a_pos, 0);
    check("t5_async_busy", a_busy, 0);
    check("t5_async_result", a_result, 0);
    check("t5_async_done", a_done, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("t5_no_done", a_done, 0);
    end
    @(negedge clk);
    reset = 1'b0;
    run_spin("t5_restart", 1'b0, 3'd1, 32, 1, 1'b1, 0, 0, 0);

    // T3: seed=3 start held from cycle 3 through DONE; landing stays at 1,
    // and the restart only comes out of IDLE one cycle after DONE.
    do_reset();
    run_spin("t3", 1'b0, 3'd1, 32, 1, 1'b0, 0, 0, 3);
    @(posedge clk);
    #1;
    check("t3_restart_busy", a_busy, 1);
    @(negedge clk);
    start = 1'b0;

    // T4: tick low for 50 clocks right after the first DECEL step (pos=5)
    do_reset();
    run_spin("t4", 1'b0, 3'd1, 82, 1, 1'b0, 10, 50, 0);

    // T6: INIT_PERIOD=MAX_PERIOD=6; first DECEL step saturates straight to LAND.
    // Steps at 6..30 (pos 1..5), LAND 6,7,0,1 at 36,42,48,54.
    do_reset();
    run_spin("t6", 1'b1, 3'd1, 54, 1, 1'b0, 0, 0, 0);
    check("t6_pos", b_pos, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
